// File: rtl/com_pkg.sv
// Shared framing definitions for the communication path (tx framer and rx deframer).
package com_pkg;

    // Default frame start byte
    localparam logic [7:0] HEAD_DEF = 8'hA5;

    // Bytes added around the payload: head, type/len-high, len-low, checksum
    localparam int unsigned FRAME_OVH = 4;

    // Packet type codes carried in the upper nibble of the type byte
    typedef enum logic [3:0] {
        BAG_INIT   = 4'h0,
        BAG_ACK    = 4'h1,
        BAG_NAK    = 4'h2,
        BAG_STL    = 4'h3,
        BAG_DIDX   = 4'h4,
        BAG_DPARAM = 4'h5,
        BAG_DDIDX  = 4'h6,
        BAG_DLINK  = 4'h7,
        BAG_DTYPE  = 4'h8,
        BAG_DTEMP  = 4'h9,
        BAG_DATA0  = 4'hD,
        BAG_DATA1  = 4'hE,
        BAG_ERROR  = 4'hF
    } bag_t;

endpackage

// File: rtl/com_tx.sv
// Transmit framer: reads a payload from packet RAM and emits
// head, type/length, payload and an XOR checksum over a valid/ready byte stream.
module com_tx
    import com_pkg::*;
#(
    parameter logic [7:0]  HEAD = HEAD_DEF,
    parameter int unsigned AW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs_tx,
    output logic          fd_tx,
    input  logic [3:0]    tx_btype,
    input  logic [AW-1:0] tx_ram_init,
    input  logic [AW-1:0] tx_ram_rlen,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HEAD,
        ST_TYPE,
        ST_LENL,
        ST_RADR,
        ST_RLAT,
        ST_RSND,
        ST_CSUM,
        ST_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    btype_q, btype_nxt;
    logic [AW-1:0] init_q, init_nxt;
    logic [AW-1:0] rlen_q, rlen_nxt;
    logic [AW-1:0] idx_q, idx_nxt;
    logic [7:0]    csum_q, csum_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt;

    // Next-state and next-datapath values; tx_data doubles as the byte register
    always_comb begin
        state_nxt = state;
        btype_nxt = btype_q;
        init_nxt  = init_q;
        rlen_nxt  = rlen_q;
        idx_nxt   = idx_q;
        csum_nxt  = csum_q;
        data_nxt  = tx_data;

        case (state)
            ST_IDLE: state_nxt = ST_WAIT;

            ST_WAIT: begin
                if (fs_tx) begin
                    btype_nxt = tx_btype;
                    init_nxt  = tx_ram_init;
                    rlen_nxt  = tx_ram_rlen;
                    idx_nxt   = '0;
                    csum_nxt  = '0;
                    data_nxt  = HEAD;
                    state_nxt = ST_HEAD;
                end
            end

            ST_HEAD: begin
                if (tx_ready) begin
                    data_nxt  = {btype_q, rlen_q[11:8]};
                    state_nxt = ST_TYPE;
                end
            end

            ST_TYPE: begin
                if (tx_ready) begin
                    csum_nxt  = csum_q ^ tx_data;
                    data_nxt  = rlen_q[7:0];
                    state_nxt = ST_LENL;
                end
            end

            ST_LENL: begin
                if (tx_ready) begin
                    csum_nxt = csum_q ^ tx_data;
                    if (rlen_q == '0) begin
                        data_nxt  = csum_nxt;
                        state_nxt = ST_CSUM;
                    end else begin
                        state_nxt = ST_RADR;
                    end
                end
            end

            ST_RADR: state_nxt = ST_RLAT;

            ST_RLAT: begin
                data_nxt  = ram_data;
                state_nxt = ST_RSND;
            end

            ST_RSND: begin
                if (tx_ready) begin
                    csum_nxt = csum_q ^ tx_data;
                    idx_nxt  = idx_q + AW'(1);
                    if (idx_nxt == rlen_q) begin
                        data_nxt  = csum_nxt;
                        state_nxt = ST_CSUM;
                    end else begin
                        state_nxt = ST_RADR;
                    end
                end
            end

            ST_CSUM: begin
                if (tx_ready) state_nxt = ST_DONE;
            end

            ST_DONE: begin
                if (!fs_tx) state_nxt = ST_WAIT;
            end

            default: state_nxt = ST_IDLE;
        endcase

        valid_nxt = (state_nxt == ST_HEAD) || (state_nxt == ST_TYPE) ||
                    (state_nxt == ST_LENL) || (state_nxt == ST_RSND) ||
                    (state_nxt == ST_CSUM);
    end

    // State and datapath registers; outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            btype_q  <= '0;
            init_q   <= '0;
            rlen_q   <= '0;
            idx_q    <= '0;
            csum_q   <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            ram_rd   <= 1'b0;
            ram_addr <= '0;
            fd_tx    <= 1'b0;
        end else begin
            state    <= state_nxt;
            btype_q  <= btype_nxt;
            init_q   <= init_nxt;
            rlen_q   <= rlen_nxt;
            idx_q    <= idx_nxt;
            csum_q   <= csum_nxt;
            tx_data  <= data_nxt;
            tx_valid <= valid_nxt;
            ram_rd   <= (state_nxt == ST_RADR);
            // Address sum is AW bits wide, so it wraps at the top of RAM
            if (state_nxt == ST_RADR) ram_addr <= init_nxt + idx_nxt;
            fd_tx    <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_com_tx.sv
// Self-checking bench for com_tx: directed frames plus randomized frames
// against a byte-level frame model and a behavioural packet RAM.
module tb_com_tx;
    import com_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs_tx = 1'b0;
    logic        fd_tx;
    logic [3:0]  tx_btype = '0;
    logic [11:0] tx_ram_init = '0;
    logic [11:0] tx_ram_rlen = '0;
    logic        ram_rd;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    int unsigned chk_cnt = 0;
    int unsigned err_cnt = 0;

    logic [7:0]  mem [4096];
    logic [7:0]  rx_q [$];
    logic [11:0] adr_q [$];
    int          ready_mode = 0;  // 0 always ready, 1 random, 2 stall on 0x22, 3 never ready
    int          stall_cnt = 0;
    int          stall22 = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    com_tx #(.HEAD(8'hA5), .AW(12)) dut (
        .clk(clk), .rst(rst), .fs_tx(fs_tx), .fd_tx(fd_tx),
        .tx_btype(tx_btype), .tx_ram_init(tx_ram_init), .tx_ram_rlen(tx_ram_rlen),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Packet RAM: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (ram_rd) ram_data <= mem[ram_addr];
    end

    // Record accepted bytes, RAM read addresses and stall stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (ram_rd) adr_q.push_back(ram_addr);
            if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_err++;
            if (tx_valid && !tx_ready && tx_data == 8'h22) stall22++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // Serializer-side ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: tx_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (tx_valid && tx_data == 8'h22 && stall_cnt < 5) begin
                        tx_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
                3: tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one packet and compare the stream with a frame built from the RAM contents
    task automatic send(input logic [3:0] bt, input logic [11:0] init,
                        input logic [11:0] rlen, input int hold, input string tag);
        logic [7:0]  exp_q [$];
        logic [11:0] exp_a [$];
        logic [7:0]  cs;
        logic [11:0] a;
        int          cyc;
        int          budget;
        exp_q.push_back(8'hA5);
        exp_q.push_back({bt, rlen[11:8]});
        exp_q.push_back(rlen[7:0]);
        cs = {bt, rlen[11:8]} ^ rlen[7:0];
        for (int i = 0; i < int'(rlen); i++) begin
            a = 12'((int'(init) + i) % 4096);
            exp_a.push_back(a);
            exp_q.push_back(mem[a]);
            cs = cs ^ mem[a];
        end
        exp_q.push_back(cs);

        rx_q.delete();
        adr_q.delete();
        tx_btype    = bt;
        tx_ram_init = init;
        tx_ram_rlen = rlen;
        @(posedge clk);
        #1;
        fs_tx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_start_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_start_head"}, 32'(tx_data), 32'hA5);

        budget = 100 + (int'(rlen) + int'(FRAME_OVH)) * 30;
        cyc = 0;
        while (!fd_tx && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(fd_tx), 32'd1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag, "_done_hold"}, 32'(fd_tx), 32'd1);
        end
        fs_tx = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_done_drop"}, 32'(fd_tx), 32'd0);

        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk({tag, "_nrd"}, 32'(adr_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < adr_q.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'(adr_q[i]), 32'(exp_a[i]));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h100] = 8'h11;
        mem[12'h101] = 8'h22;
        mem[12'h102] = 8'h33;
        mem[12'h200] = 8'h11;
        mem[12'h201] = 8'h22;
        mem[12'h202] = 8'h33;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_rd", 32'(ram_rd), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_fd", 32'(fd_tx), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Header-only frame, fd_tx held while request stays high
        send(BAG_ACK, 12'h000, 12'd0, 4, "ack");
        // Payload frame A5,D0,03,11,22,33,D3
        send(BAG_DATA0, 12'h100, 12'd3, 0, "data0");
        // Address wraps FFE, FFF, 000
        send(BAG_DATA1, 12'hFFE, 12'd3, 0, "wrap");

        // Five-cycle stall on the second payload byte
        ready_mode = 2;
        stall_cnt  = 0;
        stall22    = 0;
        stab_err   = 0;
        send(BAG_DATA0, 12'h200, 12'd3, 0, "bp");
        chk("bp_stall_cycles", 32'(stall22), 32'd5);
        chk("bp_stable", 32'(stab_err), 32'd0);
        ready_mode = 0;

        // Reset while a payload byte is presented
        ready_mode  = 3;
        rx_q.delete();
        tx_btype    = BAG_DATA0;
        tx_ram_init = 12'h300;
        tx_ram_rlen = 12'd5;
        @(posedge clk);
        #1;
        fs_tx = 1'b1;
        cyc = 0;
        // Header bytes never accepted with ready low: release briefly to reach payload
        ready_mode = 0;
        while (rx_q.size() < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        ready_mode = 3;
        cyc = 0;
        while (!(tx_valid && rx_q.size() >= 3) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_in_payload", 32'(tx_valid && rx_q.size() >= 3), 32'd1);
        rst   = 1'b1;
        fs_tx = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        rst = 1'b0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        send(BAG_DATA0, 12'h300, 12'd5, 0, "after_rst");

        // Held request gives no second frame; a new edge re-sends the same frame
        send(BAG_DTEMP, 12'h050, 12'd2, 20, "retx_a");
        send(BAG_DTEMP, 12'h050, 12'd2, 0, "retx_b");

        // Randomized frames with random backpressure
        ready_mode = 1;
        stab_err   = 0;
        for (int n = 0; n < 20; n++) begin
            send(4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)),
                 12'($urandom_range(0, 24)), int'($urandom_range(0, 3)),
                 $sformatf("rnd%0d", n));
        end
        chk("rnd_stable", 32'(stab_err), 32'd0);
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/com_tx.md
# com_tx

Transmit framer for the communication path. It accepts a send request from the upstream command/answer sequencer over the `fs_tx`/`fd_tx` handshake, together with a packet type, a RAM start address and a payload length. It reads the payload bytes from the shared packet RAM and emits a framed byte stream: head, type/length, payload, checksum. The stream goes to the line-side serializer over a valid/ready byte interface.

## Interface
Parameters:
- `HEAD`, 8'hA5: frame start byte.
- `AW`, 12: RAM address width. Also the width of `tx_ram_init` and `tx_ram_rlen`.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `fs_tx`  in  1: send request (level).
- `fd_tx`  out  1: send done.
- `tx_btype`  in  4: packet type code, from the shared `BAG_*` set.
- `tx_ram_init`  in  AW: RAM address of the first payload byte.
- `tx_ram_rlen`  in  AW: payload byte count. 0 means no payload.
- `ram_rd`  out  1: RAM read strobe.
- `ram_addr`  out  AW: RAM read address.
- `ram_data`  in  8: RAM read data. Valid one cycle after `ram_rd`.
- `tx_data`  out  8: stream byte.
- `tx_valid`  out  1: stream byte valid.
- `tx_ready`  in  1: serializer accepts the byte.

## Operation
- States: IDLE, WAIT, HEAD, TYPE, LENL, RADR, RLAT, RSND, CSUM, DONE.
- IDLE lasts one cycle, then the FSM goes to WAIT.
- WAIT:
  - When `fs_tx` = 1, latch `tx_btype`, `tx_ram_init` and `tx_ram_rlen`, clear the checksum and byte index, then go to HEAD.
  - Inputs are sampled only in WAIT and are ignored for the rest of the packet.
- Byte states and their contents:
  - HEAD presents `HEAD`.
  - TYPE presents {btype, rlen[11:8]}.
  - LENL presents rlen[7:0].
  - CSUM presents the checksum.
  - Each byte state holds its byte until `tx_ready` = 1, then advances.
- Checksum: XOR of every accepted byte except HEAD, i.e. TYPE, LENL and all payload bytes.
- After LENL is accepted:
  - rlen == 0: go to CSUM.
  - Otherwise: go to RADR.
- Payload loop:
  - RADR: `ram_rd` = 1, `ram_addr` = init + idx, truncated to AW bits so the address wraps 0xFFF -> 0x000.
  - RLAT: capture `ram_data` into the byte register.
  - RSND: present the byte. On acceptance, idx += 1, then:
    - idx == rlen: go to CSUM.
    - Otherwise: go to RADR.
- After CSUM is accepted, go to DONE.
- DONE:
  - `fd_tx` = 1.
  - Stay while `fs_tx` = 1. Return to WAIT when `fs_tx` = 0.
  - If `fs_tx` was already low, `fd_tx` is a one-cycle pulse.
- A new packet cannot start until the FSM is back in WAIT. A retransmit request therefore needs `fs_tx` low then high again.

## Timing
- Reset values:
  - FSM goes to IDLE.
  - `fd_tx` = 0, `tx_valid` = 0, `tx_data` = 8'h00, `ram_rd` = 0, `ram_addr` = 0.
  - Latched fields, checksum and idx = 0.
- Registered outputs: `tx_valid`, `tx_data`, `ram_rd`, `ram_addr`, `fd_tx`.
- `tx_valid` is 1 exactly in HEAD, TYPE, LENL, RSND and CSUM.
- Start latency: `fs_tx` sampled high in WAIT at cycle n gives `tx_valid` = 1 with `HEAD` at cycle n+1.
- Payload throughput is one byte per 3 cycles when `tx_ready` = 1. Header bytes go out 1 per cycle.
- While `tx_valid` = 1 and `tx_ready` = 0, `tx_data` must stay stable. The FSM never drops `tx_valid` before acceptance.
- `tx_ready` while `tx_valid` = 0 is ignored.
- `rst` mid-packet: the next cycle `tx_valid` = 0 and the FSM is in IDLE. No partial checksum is emitted.
- `fs_tx` falling mid-packet is ignored. The packet completes and DONE is left the next cycle.
- Frame length in bytes = rlen + 4. Maximum rlen is 4095.

## Structure
- Shared package `com_pkg`:
  - `BAG_*` type codes: INIT, ACK, NAK, STL, DIDX, DPARAM, DDIDX, DLINK, DTYPE, DTEMP, DATA0, DATA1, ERROR.
  - `HEAD` default.
  - Frame overhead constant = 4.
- The receive-side deframer reuses these definitions.
- Single module. No sub-module; the checksum is one XOR register.

## Test plan
- ACK with rlen 0: btype 4'h1, rlen 0 -> stream A5,10,00,10. `fd_tx` is high until `fs_tx` drops. `ram_rd` never asserts.
- DATA0 payload: btype 4'hD, init 0x100, rlen 3, RAM[0x100..0x102] = 11,22,33 -> stream A5,D0,03,11,22,33,D3. Exactly 3 `ram_rd` strobes.
- Address wrap: init 0xFFE, rlen 3 -> `ram_addr` sequence FFE, FFF, 000.
- Backpressure: `tx_ready` held low 5 cycles on the second payload byte -> `tx_data` = 22 and `tx_valid` = 1 stable throughout. The checksum is unaffected.
- Reset mid-payload: `rst` asserted during RSND -> `tx_valid` = 0 next cycle. A subsequent `fs_tx` produces a fresh, correct frame starting with A5.
- Retransmit: hold `fs_tx` high after DONE -> no second frame. Drop and reassert `fs_tx` -> an identical frame is re-sent.
